operand_fetch: RTL

Decode-side operand fetch and write-back control for the 5-stage RISC-V pipeline. Drives the register file's two read addresses and its write port, tracks in-flight destination registers through EX/MEM/WB in a three-entry tag pipeline, and selects forwarded operands. Asserts a one-cycle load-use stall toward fetch/decode. Sits between the ID stage and the register file.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/fwd_select.sv | 45 ++++
 rtl/operand_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, forwarding select encoding, in-flight destination tag
// and the operand/stage match helper for the 5-stage pipeline.
package pipe_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rd;
        logic             we;
        logic             is_load;
    } rd_tag_t;

    // wr is the stage's valid & we; x0 and unused operands never match
    function automatic logic src_hit(input logic wr, input logic [RADDR-1:0] rd,
                                     input logic [RADDR-1:0] src, input logic use_src);
        return wr && use_src && (src != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: one operand's stage match and EX > MEM > WB > RF forwarding mux;
// also flags an EX match on a load so the top can raise the load-use stall.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [RADDR-1:0] src_i,
    input  logic             use_i,
    input  logic [RADDR-1:0] ex_rd_i,
    input  logic             ex_wr_i,
    input  logic             ex_load_i,
    input  logic [RADDR-1:0] mem_rd_i,
    input  logic             mem_wr_i,
    input  logic [RADDR-1:0] wb_rd_i,
    input  logic             wb_wr_i,
    input  logic [XLEN-1:0]  rf_data_i,
    input  logic [XLEN-1:0]  ex_result_i,
    input  logic [XLEN-1:0]  mem_result_i,
    input  logic [XLEN-1:0]  wb_result_i,
    output logic [1:0]       sel_o,
    output logic [XLEN-1:0]  data_o,
    output logic             load_hit_o
);

    logic     ex_hit;
    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    // a load in EX has no data yet, so it never selects EX; the stall covers it
    always_comb begin
        ex_hit     = src_hit(ex_wr_i, ex_rd_i, src_i, use_i);
        mem_hit    = src_hit(mem_wr_i, mem_rd_i, src_i, use_i);
        wb_hit     = src_hit(wb_wr_i, wb_rd_i, src_i, use_i);
        load_hit_o = ex_hit & ex_load_i;
        sel        = (ex_hit && !ex_load_i) ? FWD_EX :
                     mem_hit                ? FWD_MEM :
                     wb_hit                 ? FWD_WB : FWD_RF;
        data_o     = (sel == FWD_EX)  ? ex_result_i :
                     (sel == FWD_MEM) ? mem_result_i :
                     (sel == FWD_WB)  ? wb_result_i : rf_data_i;
    end

    assign sel_o = sel;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: ID-side register file addressing, EX/MEM/WB destination tag
// pipeline, operand forwarding, load-use stall and WB register file write port.
module operand_fetch
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [XLEN-1:0]  wb_result,
    output logic [RADDR-1:0] rf_addr_rs1,
    output logic [RADDR-1:0] rf_addr_rs2,
    input  logic [XLEN-1:0]  rf_data_rs1,
    input  logic [XLEN-1:0]  rf_data_rs2,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_addr_rd,
    output logic [XLEN-1:0]  rf_data_rd,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             issue
);

    rd_tag_t ex_q;
    rd_tag_t mem_q;
    rd_tag_t wb_q;
    rd_tag_t ex_d;
    logic    load_hit_a;
    logic    load_hit_b;
    logic    unused_wb_load;

    assign rf_addr_rs1    = id_rs1;
    assign rf_addr_rs2    = id_rs2;
    assign unused_wb_load = wb_q.is_load;

    fwd_select u_fwd_a (
        .src_i        (id_rs1),
        .use_i        (id_use_rs1),
        .ex_rd_i      (ex_q.rd),
        .ex_wr_i      (ex_q.valid & ex_q.we),
        .ex_load_i    (ex_q.is_load),
        .mem_rd_i     (mem_q.rd),
        .mem_wr_i     (mem_q.valid & mem_q.we),
        .wb_rd_i      (wb_q.rd),
        .wb_wr_i      (wb_q.valid & wb_q.we),
        .rf_data_i    (rf_data_rs1),
        .ex_result_i  (ex_result),
        .mem_result_i (mem_result),
        .wb_result_i  (wb_result),
        .sel_o        (fwd_a),
        .data_o       (op_a),
        .load_hit_o   (load_hit_a)
    );

    fwd_select u_fwd_b (
        .src_i        (id_rs2),
        .use_i        (id_use_rs2),
        .ex_rd_i      (ex_q.rd),
        .ex_wr_i      (ex_q.valid & ex_q.we),
        .ex_load_i    (ex_q.is_load),
        .mem_rd_i     (mem_q.rd),
        .mem_wr_i     (mem_q.valid & mem_q.we),
        .wb_rd_i      (wb_q.rd),
        .wb_wr_i      (wb_q.valid & wb_q.we),
        .rf_data_i    (rf_data_rs2),
        .ex_result_i  (ex_result),
        .mem_result_i (mem_result),
        .wb_result_i  (wb_result),
        .sel_o        (fwd_b),
        .data_o       (op_b),
        .load_hit_o   (load_hit_b)
    );

    // flush outranks stall: a killed ID instruction needs no hold
    always_comb begin
        stall      = id_valid & ~flush & (load_hit_a | load_hit_b);
        issue      = id_valid & ~stall & ~flush;
        ex_d       = issue ? rd_tag_t'{valid: 1'b1, rd: id_rd, we: id_rd_we, is_load: id_is_load}
                           : rd_tag_t'('0);
        rf_we      = wb_q.valid & wb_q.we & (wb_q.rd != '0);
        rf_addr_rd = wb_q.rd;
        rf_data_rd = wb_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

endmodule
